// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sweep controller.
//   - Default widths and settle time used as parameter defaults by the
//     controller, its stepper and its core interface.
//   - Sweep FSM state encoding.
//   - cnt_width(): bit width of a counter that counts 0..n-1 (at least 1 bit).
package glitch_pkg;

  localparam int DEF_T_W        = 32;
  localparam int DEF_N_W        = 16;
  localparam int DEF_SETTLE_CYC = 1200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARM    = 3'd2,
    WAIT   = 3'd3,
    SETTLE = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } sweep_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glitch_sweep_ctrl_if.sv
// Connection between the sweep controller and the glitch core.
//   core_arm   : one-cycle arm pulse to the core
//   core_delay : delay setting in clk cycles
//   core_width : glitch width setting in clk cycles
//   core_done  : one-cycle pulse from the core when the glitch has completed
//   fault_in   : target misbehaviour flag, already synchronised to clk
// master = controller side, slave = glitch core / target monitor side.
interface glitch_sweep_ctrl_if #(
  parameter int T_W = glitch_pkg::DEF_T_W
);
  logic           core_arm;
  logic [T_W-1:0] core_delay;
  logic [T_W-1:0] core_width;
  logic           core_done;
  logic           fault_in;

  modport master (
    output core_arm, core_delay, core_width,
    input  core_done, fault_in
  );

  modport slave (
    input  core_arm, core_delay, core_width,
    output core_done, fault_in
  );
endinterface

// File: rtl/glitch_sweep_ctrl_sweep_stepper.sv
// Grid walker for the glitch sweep: holds the sweep settings captured at
// load time, the current (delay, width) point, the grid indices and the
// attempt counter.
// Build option: GLITCH_SWEEP_WIDTH_EN -- when defined the delay x width grid
// is walked delay-fastest; when undefined only delay points are walked and
// the width stays at width_start.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture sweep inputs and restart at the first point
//   step          : advance to the next grid point
//   delay_*/width_*: raw sweep inputs (only sampled on load)
//   cur_delay/cur_width : settings for the current point
//   attempt       : current attempt index
//   empty         : raw inputs describe a sweep with no points
//   last          : the current point is the final one of the grid
module sweep_stepper #(
  parameter int T_W = 32,
  parameter int N_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [T_W-1:0] delay_start,
  input  logic [T_W-1:0] delay_step,
  input  logic [N_W-1:0] delay_count,
  input  logic [T_W-1:0] width_start,
  input  logic [T_W-1:0] width_step,
  input  logic [N_W-1:0] width_count,
  output logic [T_W-1:0] cur_delay,
  output logic [T_W-1:0] cur_width,
  output logic [N_W-1:0] attempt,
  output logic           empty,
  output logic           last
);

  logic [T_W-1:0] d_start_reg;
  logic [T_W-1:0] d_step_reg;
  logic [N_W-1:0] d_count_reg;
  logic [T_W-1:0] cur_delay_reg;
  logic [T_W-1:0] cur_width_reg;
  logic [N_W-1:0] di_reg;
  logic [N_W-1:0] attempt_reg;
  logic           d_wrap;

  // Count is never zero here: an empty sweep never leaves LOAD for ARM.
  assign d_wrap = (di_reg == d_count_reg - N_W'(1));

`ifdef GLITCH_SWEEP_WIDTH_EN
  logic [T_W-1:0] w_step_reg;
  logic [N_W-1:0] w_count_reg;
  logic [N_W-1:0] wi_reg;

  assign empty = (delay_count == '0) || (width_count == '0);
  assign last  = d_wrap && (wi_reg == w_count_reg - N_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_step_reg    <= '0;
      w_count_reg   <= '0;
      wi_reg        <= '0;
      cur_width_reg <= '0;
    end else if (load) begin
      w_step_reg    <= width_step;
      w_count_reg   <= width_count;
      wi_reg        <= '0;
      cur_width_reg <= width_start;
    end else if (step && d_wrap) begin
      // Width moves only when the delay axis wraps.
      wi_reg        <= wi_reg + N_W'(1);
      cur_width_reg <= cur_width_reg + w_step_reg;
    end
  end
`else
  logic unused_width;
  assign unused_width = ^{width_step, width_count};

  assign empty = (delay_count == '0);
  assign last  = d_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_width_reg <= '0;
    end else if (load) begin
      cur_width_reg <= width_start;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_start_reg   <= '0;
      d_step_reg    <= '0;
      d_count_reg   <= '0;
      cur_delay_reg <= '0;
      di_reg        <= '0;
      attempt_reg   <= '0;
    end else if (load) begin
      d_start_reg   <= delay_start;
      d_step_reg    <= delay_step;
      d_count_reg   <= delay_count;
      cur_delay_reg <= delay_start;
      di_reg        <= '0;
      attempt_reg   <= '0;
    end else if (step) begin
      attempt_reg <= attempt_reg + N_W'(1);
      if (!d_wrap) begin
        di_reg        <= di_reg + N_W'(1);
        cur_delay_reg <= cur_delay_reg + d_step_reg;
      end else begin
        di_reg        <= '0;
        cur_delay_reg <= d_start_reg;
      end
    end
  end

  assign cur_delay = cur_delay_reg;
  assign cur_width = cur_width_reg;
  assign attempt   = attempt_reg;

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// Glitch parameter sweep controller. Walks a grid of (delay, width) points,
// arms the glitch core once per point, watches fault_in for SETTLE_CYC
// cycles after each glitch and reports the settings of faulting attempts.
// Build option: GLITCH_SWEEP_WIDTH_EN -- sweep the full delay x width grid;
// undefined (default) sweeps delay points only at width_start.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : level sweep request (IDLE only); DONE waits for it to drop
//   abort               : return to IDLE from any state, highest priority
//   delay_start/step/count, width_start/step/count : sweep settings
//   core                : glitch core connection (arm, settings, done, fault_in)
//   busy, done          : sweep status
//   hit                 : one-cycle pulse for a faulting attempt
//   hit_delay/hit_width : settings of the most recent hit
//   attempt             : current attempt index from 0
module glitch_sweep_ctrl
  import glitch_pkg::*;
#(
  parameter int T_W        = DEF_T_W,
  parameter int N_W        = DEF_N_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [T_W-1:0]             delay_start,
  input  logic [T_W-1:0]             delay_step,
  input  logic [N_W-1:0]             delay_count,
  input  logic [T_W-1:0]             width_start,
  input  logic [T_W-1:0]             width_step,
  input  logic [N_W-1:0]             width_count,
  glitch_sweep_ctrl_if.master        core,
  output logic                       busy,
  output logic                       done,
  output logic                       hit,
  output logic [T_W-1:0]             hit_delay,
  output logic [T_W-1:0]             hit_width,
  output logic [N_W-1:0]             attempt
);

  localparam int             S_W         = cnt_width(SETTLE_CYC);
  localparam logic [S_W-1:0] SETTLE_LAST = S_W'(SETTLE_CYC - 1);

  sweep_state_t   state_reg, state_next;
  logic [S_W-1:0] settle_cnt_reg;
  logic           fault_seen_reg;
  logic [T_W-1:0] hit_delay_reg;
  logic [T_W-1:0] hit_width_reg;

  logic           load_go, step_go, arm_now, hit_now, settle_clr;
  logic           sweep_empty, sweep_last;
  logic [T_W-1:0] cur_delay, cur_width;

  sweep_stepper #(
    .T_W (T_W),
    .N_W (N_W)
  ) u_stepper (
    .clk         (clk),
    .rst         (rst),
    .load        (load_go),
    .step        (step_go),
    .delay_start (delay_start),
    .delay_step  (delay_step),
    .delay_count (delay_count),
    .width_start (width_start),
    .width_step  (width_step),
    .width_count (width_count),
    .cur_delay   (cur_delay),
    .cur_width   (cur_width),
    .attempt     (attempt),
    .empty       (sweep_empty),
    .last        (sweep_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_go    = 1'b0;
    step_go    = 1'b0;
    arm_now    = 1'b0;
    hit_now    = 1'b0;
    settle_clr = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        load_go    = 1'b1;
        state_next = sweep_empty ? DONE : ARM;
      end
      ARM: begin
        arm_now    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core.core_done) begin
          settle_clr = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) state_next = NEXT;
      end
      NEXT: begin
        hit_now    = fault_seen_reg;
        step_go    = 1'b1;
        state_next = sweep_last ? DONE : ARM;
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including the pulses of this cycle.
    if (abort) begin
      state_next = IDLE;
      load_go    = 1'b0;
      step_go    = 1'b0;
      arm_now    = 1'b0;
      hit_now    = 1'b0;
      settle_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt_reg <= '0;
      fault_seen_reg <= 1'b0;
      hit_delay_reg  <= '0;
      hit_width_reg  <= '0;
    end else begin
      if (settle_clr) begin
        settle_cnt_reg <= '0;
        fault_seen_reg <= 1'b0;
      end else if (state_reg == SETTLE) begin
        settle_cnt_reg <= settle_cnt_reg + S_W'(1);
        fault_seen_reg <= fault_seen_reg | core.fault_in;
      end
      // Capture on the way into NEXT so the settings are already valid
      // while hit is high; a fault on the final settle cycle still counts.
      if ((state_reg == SETTLE) && (state_next == NEXT) &&
          (fault_seen_reg || core.fault_in)) begin
        hit_delay_reg <= cur_delay;
        hit_width_reg <= cur_width;
      end
    end
  end

  assign core.core_arm   = arm_now;
  assign core.core_delay = cur_delay;
  assign core.core_width = cur_width;

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign hit       = hit_now;
  assign hit_delay = hit_delay_reg;
  assign hit_width = hit_width_reg;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl. A small in-bench core model answers
// each core_arm with core_done after CORE_LAT cycles and can pulse fault_in
// inside the settle window of a chosen attempt. Every observed arm and hit
// is logged and compared against a table of hand-computed points.
module tb_glitch_sweep_ctrl;

  localparam int T_W      = 32;
  localparam int N_W      = 16;
  localparam int SETTLE   = 12;
  localparam int CORE_LAT = 3;
  // ARM, CORE_LAT WAIT cycles, SETTLE cycles, NEXT -> next ARM
  localparam int GAP      = SETTLE + CORE_LAT + 2;
`ifdef GLITCH_SWEEP_WIDTH_EN
  localparam int             N_EXP     = 6;
  localparam int             FAULT_IDX = 4;
  localparam logic [T_W-1:0] HIT_W     = 32'd7;
`else
  localparam int             N_EXP     = 3;
  localparam int             FAULT_IDX = 1;
  localparam logic [T_W-1:0] HIT_W     = 32'd5;
`endif

  typedef struct {
    logic [T_W-1:0] d;
    logic [T_W-1:0] w;
    int             a;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, start, abort;
  logic [T_W-1:0] delay_start, delay_step, width_start, width_step;
  logic [N_W-1:0] delay_count, width_count;
  logic           busy, done, hit;
  logic [T_W-1:0] hit_delay, hit_width;
  logic [N_W-1:0] attempt;

  glitch_sweep_ctrl_if #(.T_W(T_W)) ci ();

  glitch_sweep_ctrl #(
    .T_W        (T_W),
    .N_W        (N_W),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .delay_start (delay_start),
    .delay_step  (delay_step),
    .delay_count (delay_count),
    .width_start (width_start),
    .width_step  (width_step),
    .width_count (width_count),
    .core        (ci),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .hit_delay   (hit_delay),
    .hit_width   (hit_width),
    .attempt     (attempt)
  );

  always #5 clk = ~clk;

  vec_t           exp_tbl [6];
  logic [T_W-1:0] arm_d [64];
  logic [T_W-1:0] arm_w [64];
  int             arm_a [64];
  int             arm_cyc [64];
  int             n_arm, n_hit, cyc, lat_cnt, flt_cnt, fault_idx;
  int             n_pass, n_total;
  bit             abort_on_done, abort_fired;
  logic [T_W-1:0] hit_d_seen, hit_w_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: observe at the falling edge, then drive the core model's
  // inputs for the next rising edge.
  task automatic cycle();
    bit saw_arm;
    @(negedge clk);
    cyc++;
    saw_arm = (ci.core_arm === 1'b1);
    if (saw_arm) begin
      if (n_arm < 64) begin
        arm_d[n_arm]   = ci.core_delay;
        arm_w[n_arm]   = ci.core_width;
        arm_a[n_arm]   = int'(attempt);
        arm_cyc[n_arm] = cyc;
      end
      $display("arm %0d: delay=0x%0h width=0x%0h attempt=%0d", n_arm, ci.core_delay, ci.core_width, attempt);
      n_arm++;
    end
    if (hit === 1'b1) begin
      n_hit++;
      hit_d_seen = hit_delay;
      hit_w_seen = hit_width;
      $display("hit: delay=0x%0h width=0x%0h", hit_delay, hit_width);
    end
    ci.core_done = 1'b0;
    ci.fault_in  = 1'b0;
    abort        = 1'b0;
    if (flt_cnt > 0) begin
      flt_cnt--;
      if (flt_cnt == 0) ci.fault_in = 1'b1;
    end
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        ci.core_done = 1'b1;
        if (abort_on_done) begin
          abort       = 1'b1;
          abort_fired = 1'b1;
        end
        if (n_arm - 1 == fault_idx) flt_cnt = 4;
      end
    end
    if (saw_arm) lat_cnt = CORE_LAT;
  endtask

  task automatic clear_log();
    n_arm = 0;
    n_hit = 0;
    hit_d_seen = '0;
    hit_w_seen = '0;
  endtask

  task automatic set_cfg();
    delay_start = 32'd100; delay_step = 32'd10; delay_count = 16'd3;
    width_start = 32'd5;   width_step = 32'd2;  width_count = 16'd2;
  endtask

  task automatic start_sweep();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    i = 0;
    while (done !== 1'b1 && i < max) begin
      cycle();
      i++;
    end
    chk({tag, " reached done"}, done, 1);
    chk({tag, " busy low in done"}, busy, 0);
  endtask

  task automatic chk_grid(input string tag);
    chk({tag, " arm count"}, n_arm, N_EXP);
    for (int i = 0; i < N_EXP; i++) begin
      chk($sformatf("%s arm%0d delay", tag, i), arm_d[i], exp_tbl[i].d);
      chk($sformatf("%s arm%0d width", tag, i), arm_w[i], exp_tbl[i].w);
      chk($sformatf("%s arm%0d attempt", tag, i), arm_a[i], exp_tbl[i].a);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int i;
    exp_tbl[0] = '{32'd100, 32'd5, 0};
    exp_tbl[1] = '{32'd110, 32'd5, 1};
    exp_tbl[2] = '{32'd120, 32'd5, 2};
    exp_tbl[3] = '{32'd100, 32'd7, 3};
    exp_tbl[4] = '{32'd110, 32'd7, 4};
    exp_tbl[5] = '{32'd120, 32'd7, 5};

    n_pass = 0; n_total = 0; cyc = 0;
    lat_cnt = 0; flt_cnt = 0; fault_idx = -1;
    abort_on_done = 1'b0; abort_fired = 1'b0;
    clear_log();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    ci.core_done = 1'b0; ci.fault_in = 1'b0;
    set_cfg();

    // Reset state
    cycle();
    cycle();
    chk("rst core_arm", ci.core_arm, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hit", hit, 0);
    chk("rst attempt", attempt, 0);
    chk("rst core_delay", ci.core_delay, 0);
    rst = 1'b0;
    cycle();
    chk("idle busy", busy, 0);

    // Full grid, no faults; inputs scrambled after LOAD must be ignored
    clear_log();
    start_sweep();
    chk("t1 busy in load", busy, 1);
    cycle();
    cycle();
    delay_start = 32'd7; delay_step = 32'd1; delay_count = 16'd9;
    width_start = 32'd1; width_step = 32'd1; width_count = 16'd9;
    wait_done("t1", 2000);
    chk_grid("t1");
    for (int k = 1; k < N_EXP; k++)
      chk($sformatf("t1 arm gap %0d", k), arm_cyc[k] - arm_cyc[k-1], GAP);
    chk("t1 hits", n_hit, 0);
    cycle();
    chk("t1 idle after done", done, 0);

    // Fault in one attempt, start held high through completion
    set_cfg();
    clear_log();
    fault_idx = FAULT_IDX;
    start = 1'b1;
    wait_done("t2", 2000);
    chk("t2 hit count", n_hit, 1);
    chk("t2 hit_delay", hit_d_seen, 32'd110);
    chk("t2 hit_width", hit_w_seen, HIT_W);
    chk("t2 arm count", n_arm, N_EXP);
    repeat (5) cycle();
    chk("t2 done held", done, 1);
    chk("t2 no relaunch", n_arm, N_EXP);
    chk("t2 hit_delay held", hit_delay, 32'd110);
    start = 1'b0;
    cycle();
    chk("t2 idle done", done, 0);
    chk("t2 idle busy", busy, 0);
    fault_idx = -1;

    // Empty sweep
    delay_count = 16'd0;
    clear_log();
    start = 1'b1;
    cycle();
    cycle();
    chk("t3 done in 2", done, 1);
    chk("t3 attempt", attempt, 0);
    chk("t3 no arm", n_arm, 0);
    start = 1'b0;
    cycle();
    chk("t3 idle", done, 0);
    set_cfg();

    // Abort together with core_done in WAIT
    clear_log();
    fault_idx = 0;
    abort_on_done = 1'b1;
    abort_fired = 1'b0;
    start_sweep();
    i = 0;
    while (!abort_fired && i < 100) begin
      cycle();
      i++;
    end
    chk("t4 abort issued", abort_fired, 1);
    chk("t4 busy in wait", busy, 1);
    abort_on_done = 1'b0;
    cycle();
    chk("t4 idle busy", busy, 0);
    chk("t4 idle done", done, 0);
    repeat (40) cycle();
    chk("t4 arm count", n_arm, 1);
    chk("t4 no hit", n_hit, 0);
    fault_idx = -1;

    // Reset in SETTLE after a fault was seen, then a clean rerun
    clear_log();
    fault_idx = 0;
    start_sweep();
    i = 0;
    while (n_arm < 1 && i < 100) begin
      cycle();
      i++;
    end
    chk("t5 first arm", n_arm, 1);
    repeat (9) cycle();
    chk("t5 busy in settle", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5 rst core_arm", ci.core_arm, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst hit", hit, 0);
    chk("t5 rst hit_delay", hit_delay, 0);
    chk("t5 rst hit_width", hit_width, 0);
    chk("t5 rst core_delay", ci.core_delay, 0);
    chk("t5 rst core_width", ci.core_width, 0);
    chk("t5 rst attempt", attempt, 0);
    cycle();
    rst = 1'b0;
    lat_cnt = 0; flt_cnt = 0; fault_idx = -1;
    clear_log();
    cycle();
    start_sweep();
    wait_done("t5", 2000);
    chk_grid("t5");
    chk("t5 no hit", n_hit, 0);
    chk("t5 hit_delay clear", hit_delay, 0);
    cycle();

    // Delay accumulator wraps modulo 2^T_W
    delay_start = 32'hFFFF_FFF0; delay_step = 32'h20; delay_count = 16'd3;
    width_count = 16'd1;
    clear_log();
    start_sweep();
    wait_done("t6", 2000);
    chk("t6 arm count", n_arm, 3);
    chk("t6 arm0 delay", arm_d[0], 32'hFFFF_FFF0);
    chk("t6 arm1 delay", arm_d[1], 32'h0000_0010);
    chk("t6 arm2 delay", arm_d[2], 32'h0000_0030);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glitch_sweep_ctrl.md
GLITCH_SWEEP_CTRL -- requirements
Module: glitch_sweep_ctrl

Interface
REQ-001 SHALL have parameter T_W, default 32, giving the width of the delay and width timing fields in clk cycles.
REQ-002 SHALL have parameter N_W, default 16, giving the width of the step-count and attempt-index fields.
REQ-003 SHALL have parameter SETTLE_CYC, default 1200, giving the cycles after core_done during which fault_in is observed.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, level-sampled sweep request, honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, returns to IDLE from any state.
REQ-008 SHALL have ports delay_start / delay_step, input, T_W, first delay and delay increment.
REQ-009 SHALL have port delay_count, input, N_W, number of delay points.
REQ-010 SHALL have ports width_start / width_step, input, T_W, first glitch width and width increment.
REQ-011 SHALL have port width_count, input, N_W, number of width points.
REQ-012 SHALL have port core_arm, output, 1, one-cycle arm pulse to the glitch core.
REQ-013 SHALL have ports core_delay / core_width, output, T_W, settings for the glitch core.
REQ-014 SHALL have port core_done, input, 1, one-cycle pulse from the core when the glitch completes.
REQ-015 SHALL have port fault_in, input, 1, target-misbehaviour indication, already synchronised to clk.
REQ-016 SHALL have ports busy and done, output, 1, sweep status; done is high in DONE only.
REQ-017 SHALL have port hit, output, 1, one-cycle pulse when an attempt produces a fault.
REQ-018 SHALL have ports hit_delay / hit_width, output, T_W, settings of the most recent hit.
REQ-019 SHALL have port attempt, output, N_W, index of the current attempt, counted from 0.

Function
REQ-020 SHALL use states IDLE, LOAD, ARM, WAIT, SETTLE, NEXT and DONE.
REQ-021 SHALL move IDLE->LOAD when start=1.
- If delay_count=0 or width_count=0: LOAD->DONE, with no core_arm issued.
REQ-022 SHALL in LOAD set cur_delay=delay_start, cur_width=width_start, di=0, wi=0, attempt=0, and register all sweep inputs; later input changes are ignored until the next sweep.
REQ-023 SHALL in ARM assert core_arm for exactly one cycle, then go to WAIT; core_delay/core_width are stable from ARM until the state leaves SETTLE.
REQ-024 SHALL in WAIT hold until core_done=1, then go to SETTLE with the settle counter cleared and fault_seen cleared.
REQ-025 SHALL in SETTLE set fault_seen on any fault_in=1 cycle, and leave after exactly SETTLE_CYC cycles.
REQ-026 SHALL, when fault_seen=1 on leaving SETTLE, pulse hit in the NEXT cycle and load hit_delay/hit_width with the current settings.
REQ-027 SHALL in NEXT advance as follows:
- If di<delay_count-1: di+1 and cur_delay+=delay_step.
- Otherwise: di=0, cur_delay=delay_start, wi+1 and cur_width+=width_step.
- attempt+1.
- Go to ARM, or to DONE once the last (di,wi) point is finished.
REQ-028 SHALL wrap all additions modulo 2^T_W without saturation.
REQ-029 SHALL hold DONE until start=0, then go to IDLE; a start still high at completion does not re-launch a sweep.
REQ-030 SHALL on abort=1 go to IDLE next cycle and suppress core_arm and hit that cycle; abort takes priority over core_done, hit and start.
REQ-031 SHALL make busy=1 in every state except IDLE and DONE.

Reset
REQ-032 SHALL on rst force state=IDLE and set core_arm, busy, done, hit, hit_delay, hit_width, core_delay, core_width, attempt and all counters to 0, asynchronously; release is synchronous to clk.
REQ-033 SHALL treat a reset mid-sweep as a full discard; no hit is reported for the interrupted attempt.

Configuration
REQ-034 SHALL, with GLITCH_SWEEP_WIDTH_EN defined, sweep the full delay x width grid as per REQ-027.
REQ-035 SHALL, without GLITCH_SWEEP_WIDTH_EN, ignore width_step and width_count, drive core_width=width_start, and sweep delay points only, so that the total attempts equal delay_count.

Structure
REQ-036 SHALL place the state enum and default timing constants (T_W, N_W, SETTLE_CYC) in shared package glitch_pkg.
REQ-037 SHALL implement the grid index/accumulator logic as sub-module sweep_stepper; the FSM and settle counter remain in glitch_sweep_ctrl.

Verification
REQ-038 SHALL cover a 3x2 grid (delay_start=100, step=10, width_start=5, step=2) with no faults: the bench sees 6 core_arm pulses with (delay,width) = (100,5) (110,5) (120,5) (100,7) (110,7) (120,7), then done=1.
REQ-039 SHALL cover fault_in pulsed 1 cycle inside SETTLE of attempt 4: hit pulses once, with hit_delay=110 and hit_width=7.
REQ-040 SHALL cover delay_count=0 with start: DONE within 2 cycles, no core_arm, and attempt=0.
REQ-041 SHALL cover abort asserted in WAIT on the same cycle as core_done: IDLE next cycle, no hit, and no further core_arm.
REQ-042 SHALL cover rst asserted in SETTLE: all outputs 0 immediately; after release, a new start reproduces REQ-038 from (100,5).
REQ-043 SHALL cover delay_start=0xFFFF_FFF0 with step=0x20: the second attempt drives core_delay=0x10.
